wb_gpio_bridge: RTL and testbench

//  Wishbone B4 classic slave feeding the GPIO register port (addr/we/wdata/rdata) directly downstream.

---
 rtl/gpio_wb_pkg.sv | 39 +++
 rtl/wb_gpio_bridge.sv | 152 +++++++++++++++
 tb/tb_wb_gpio_bridge.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_wb_pkg.sv
// Shared types for the Wishbone-to-GPIO register bridge:
// FSM encoding, register offsets and the byte-lane merge helper.
package gpio_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_DIR = 2'b00;
    localparam logic [1:0] OFF_OUT = 2'b01;
    localparam logic [1:0] OFF_IN  = 2'b10;
    localparam logic [1:0] OFF_RSV = 2'b11;

    localparam logic [3:0] SEL_FULL = 4'hF;
    localparam logic [3:0] SEL_NONE = 4'h0;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [3:0] sel;
        logic       bad;
    } req_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_gpio_bridge.sv
// Wishbone B4 classic slave driving the GPIO register port, with RMW for partial writes.
// Define GPIO_WB_ERR_EN to answer illegal accesses with wb_err_o instead of wb_ack_o.
module wb_gpio_bridge
    import gpio_wb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [1:0]          reg_addr,
    output logic                reg_we,
    output logic [DATA_W-1:0]   reg_wdata,
    input  logic [DATA_W-1:0]   reg_rdata
);

`ifdef GPIO_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    state_t              state_q;
    state_t              state_d;
    req_t                req_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic req;
    logic is_read;
    logic is_full;
    logic is_none;
    logic is_part;
    logic wr_ok;
    logic req_bad;
    logic rd_keep;
    logic adr_unused;

    assign req     = wb_cyc_i & wb_stb_i;
    assign is_read = ~wb_we_i;
    assign is_full = wb_we_i & (wb_sel_i == SEL_FULL);
    assign is_none = wb_we_i & (wb_sel_i == SEL_NONE);
    assign is_part = wb_we_i & ~is_full & ~is_none;

    // Only DIR and OUT are writable; IN and the reserved slot never see reg_we.
    assign req_bad = (wb_we_i & wb_adr_i[3])
                   | (~wb_we_i & (wb_adr_i[3:2] == OFF_RSV));
    assign wr_ok   = ~req_q.addr[1];
    assign rd_keep = ERR_EN & req_q.bad;

    assign adr_unused = ^{wb_adr_i[ADDR_W-1:4], wb_adr_i[1:0]};

    assign reg_addr  = req_q.addr;
    assign reg_wdata = wdata_q;
    assign wb_dat_o  = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reg_we   = 1'b0;
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    unique case (1'b1)
                        is_read: state_d = ST_RD;
                        is_full: state_d = ST_WR;
                        is_none: state_d = ST_ACK;
                        is_part: state_d = ST_RD;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RD: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (req_q.we) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_WR: begin
                // The write commits even if the master abandons the cycle here.
                reg_we  = wr_ok;
                state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
            end
            ST_ACK: begin
`ifdef GPIO_WB_ERR_EN
                if (req_q.bad) begin
                    wb_err_o = wb_cyc_i;
                end else begin
                    wb_ack_o = wb_cyc_i;
                end
`else
                wb_ack_o = wb_cyc_i;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        req_q.we   <= wb_we_i;
                        req_q.addr <= wb_adr_i[3:2];
                        req_q.sel  <= wb_sel_i;
                        req_q.bad  <= req_bad;
                        wdata_q    <= wb_dat_i;
                    end
                end
                ST_RD: begin
                    if (wb_cyc_i) begin
                        if (req_q.we) begin
                            wdata_q <= merge_bytes(reg_rdata, wdata_q, req_q.sel);
                        end else if (!rd_keep) begin
                            rdata_q <= (req_q.addr == OFF_RSV) ? '0 : reg_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_gpio_bridge.sv
// Directed bench for wb_gpio_bridge with a transaction-level model and per-cycle compare.
// Expectations follow GPIO_WB_ERR_EN when the bench is built with it defined.
module tb_wb_gpio_bridge;

`ifdef GPIO_WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [31:0] G_IN = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [1:0]  reg_addr;
    logic        reg_we;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    wb_gpio_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .reg_addr  (reg_addr),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // GPIO register file emulation driven by the DUT's register port.
    logic [31:0] g_dir = '0;
    logic [31:0] g_out = '0;

    always_comb begin
        case (reg_addr)
            2'b00:   reg_rdata = g_dir;
            2'b01:   reg_rdata = g_out;
            2'b10:   reg_rdata = G_IN;
            default: reg_rdata = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        if (reg_we) begin
            if (reg_addr == 2'b00) g_dir <= reg_wdata;
            else if (reg_addr == 2'b01) g_out <= reg_wdata;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_n, act, exp);
        end
    endtask

    // Model state and per-cycle expectation schedule.
    logic [31:0] m_reg [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    bit          exp_ack [int];
    bit          exp_err [int];
    bit          exp_we  [int];
    bit          exp_clr [int];
    logic [31:0] exp_wd  [int];
    logic [1:0]  exp_wa  [int];
    logic [31:0] exp_dat_at [int];
    logic [31:0] cur_dat;
    logic [31:0] last_wd = '0;
    logic [1:0]  last_wa = '0;

    always @(negedge clk) begin
        if (cyc_n >= 1) begin
            bit ew;
            ew = exp_we.exists(cyc_n);
            if (exp_dat_at.exists(cyc_n)) cur_dat = exp_dat_at[cyc_n];
            chk("ack", 32'(wb_ack_o), 32'(exp_ack.exists(cyc_n)));
            chk("err", 32'(wb_err_o), 32'(exp_err.exists(cyc_n)));
            chk("reg_we", 32'(reg_we), 32'(ew));
            if (ew) begin
                chk("reg_wdata", reg_wdata, exp_wd[cyc_n]);
                chk("reg_addr", 32'(reg_addr), 32'(exp_wa[cyc_n]));
            end
            if (exp_clr.exists(cyc_n)) begin
                chk("rst_reg_addr", 32'(reg_addr), 32'h0);
                chk("rst_reg_wdata", reg_wdata, 32'h0);
            end
            chk("wb_dat_o", wb_dat_o, cur_dat);
            if (reg_we) begin
                last_wd = reg_wdata;
                last_wa = reg_addr;
            end
        end
    end

    // Called #1 after a posedge with the bus idle; returns #1 after the
    // posedge at which the master samples the (expected) ack.
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int drop, input bit stb_gap);
        int s, lat, aw, ww, d;
        logic [1:0]  off;
        logic [31:0] m, nv;
        bit is_bad, wr;
        off    = adr[3:2];
        is_bad = ERR_EN && ((we && off[1]) || (!we && off == 2'b11));
        if (!we) lat = 2;
        else if (sel == 4'hF) lat = 2;
        else if (sel == 4'h0) lat = 1;
        else lat = 3;
        s  = cyc_n + 1;
        aw = s + lat - 1;
        ww = aw - 1;
        d  = (drop > 0) ? s + drop - 1 : aw + 10;
        wr = we && (sel != 4'h0) && !off[1];
        if (wr && d >= ww) begin
            m  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            nv = (dat & m) | (m_reg[off] & ~m);
            m_reg[off] = nv;
            exp_we[ww] = 1'b1;
            exp_wd[ww] = nv;
            exp_wa[ww] = off;
        end
        if (!we && !is_bad && d >= aw) begin
            exp_dat_at[aw] = (off == 2'b11) ? 32'h0 : (off == 2'b10) ? G_IN : m_reg[off];
        end
        if (d > aw) begin
            if (is_bad) exp_err[aw] = 1'b1;
            else exp_ack[aw] = 1'b1;
        end
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        while (cyc_n <= aw) begin
            @(posedge clk);
            #1;
            if (cyc_n == d) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            if (stb_gap && cyc_n == s) wb_stb_i = 1'b0;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_partial(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int s;
        s = cyc_n + 1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        @(posedge clk);
        #1;
        exp_dat_at[s + 1] = 32'h0;
        exp_clr[s + 1]    = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_dat_at[1] = 32'h0;
        for (int i = 1; i <= 3; i++) exp_clr[i] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(1'b1, 32'h0, 32'h0000_00FF, 4'hF, 0, 1'b0);
        chk("t1_wdata", last_wd, 32'h0000_00FF);
        chk("t1_waddr", 32'(last_wa), 32'h0);

        xfer(1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 0, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0);
        chk("t2_rdata", wb_dat_o, 32'hA5A5_A5A5);

        xfer(1'b1, 32'h4, 32'h1122_3344, 4'hF, 0, 1'b0);
        xfer(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101, 0, 1'b0);
        chk("t3_merge", last_wd, 32'h11BB_33DD);

        xfer(1'b0, 32'h0, 32'h0, 4'hF, 1, 1'b0);
        chk("t4_abort_hold", wb_dat_o, 32'hA5A5_A5A5);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0);
        chk("t4_after_abort", wb_dat_o, 32'h0000_00FF);

        xfer(1'b1, 32'h8, 32'h0000_1234, 4'hF, 0, 1'b0);
        xfer(1'b1, 32'hC, 32'h5555_5555, 4'h3, 0, 1'b0);
        xfer(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0);
        chk("t5_read_in", wb_dat_o, G_IN);
        xfer(1'b0, 32'hC, 32'h0, 4'hF, 0, 1'b0);
        xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);

        rst_partial(32'h4, 32'hFFFF_FFFF, 4'h1);
        chk("t6_dat_cleared", wb_dat_o, 32'h0);

        xfer(1'b1, 32'h4, 32'hCAFE_0001, 4'hF, 1, 1'b0);
        xfer(1'b1, 32'h0, 32'h0000_F00D, 4'hF, 2, 1'b0);
        xfer(1'b1, 32'h4, 32'h9988_7766, 4'b1000, 2, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b1);
        chk("t7_stb_gap", wb_dat_o, 32'h0000_F00D);
        xfer(1'b0, 32'h4, 32'h0, 4'hF, 2, 1'b0);
        chk("t7_final_out", wb_dat_o, 32'h99FE_0001);
        chk("t7_gpio_out", g_out, 32'h99FE_0001);
        chk("t7_gpio_dir", g_dir, 32'h0000_F00D);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
